alu_issue_ctrl: RTL and testbench

Sequential issue/writeback controller on the driving side of the combinational ALU. Accepts one operation per handshake, latches the operands and presents them to the ALU, captures the ALU's R/S/exception results and writes them to the register file. Filters the cases the ALU cannot handle (divide by zero, zero-distance rotates, out-of-range shift counts) and reports exceptions through a held, acknowledged flag.

---
 rtl/alu_issue_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Purpose: issue/writeback controller driving a combinational ALU; filters unsupported ops into a held exception.
// Latency: transfer to first wb_en is 2 cycles (1 for zero-distance rotate); 1 op per 3 cycles, 4 for MUL/DIV.
// Backpressure: op_ready is registered and high only in IDLE; an exception holds the block until exc_ack.
//
// Ports: clk/rst (sync, active high); op_valid/op_ready/op_func/op_a/op_b/op_rd request handshake;
//        alu_a/alu_b/alu_ctrl registered ALU operands, alu_r/alu_s/alu_exc ALU results;
//        wb_en/wb_addr/wb_data register-file write; exc_valid/exc_code/exc_ack exception flag;
//        stat_ops/stat_exc saturating counters, present only when ALU_ISSUE_STATS_EN is defined (else 0).
module alu_issue_ctrl #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    CTRL_WIDTH = 4,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] S_REG_ADDR = 4'd15,
  parameter logic [CTRL_WIDTH-1:0] FN_ADD     = 4'b1111,
  parameter logic [CTRL_WIDTH-1:0] FN_SUB     = 4'b1110,
  parameter logic [CTRL_WIDTH-1:0] FN_AND     = 4'b1101,
  parameter logic [CTRL_WIDTH-1:0] FN_OR      = 4'b1100,
  parameter logic [CTRL_WIDTH-1:0] FN_MUL     = 4'b0001,
  parameter logic [CTRL_WIDTH-1:0] FN_DIV     = 4'b0010,
  parameter logic [CTRL_WIDTH-1:0] FN_SLL     = 4'b1010,
  parameter logic [CTRL_WIDTH-1:0] FN_SLR     = 4'b1011,
  parameter logic [CTRL_WIDTH-1:0] FN_ROL     = 4'b1001,
  parameter logic [CTRL_WIDTH-1:0] FN_ROR     = 4'b1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [CTRL_WIDTH-1:0] op_func,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [ADDR_WIDTH-1:0] op_rd,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH:0]   alu_r,
  input  logic [DATA_WIDTH:0]   alu_s,
  input  logic                  alu_exc,
  output logic                  wb_en,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  exc_valid,
  output logic [1:0]            exc_code,
  input  logic                  exc_ack,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_exc
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, EXEC, WB_R, WB_S, EXC} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] s_q;
  logic                  long_q;   // op writes both R and S (MUL/DIV)

  logic                  fn_valid, fn_shift, fn_rot, fn_long;
  logic                  div_zero, rot_zero;
  logic [DATA_WIDTH-1:0] b_eff;

  // The ALU's carry/extension bit is not part of the register write.
  logic unused_hi;
  assign unused_hi = alu_r[DATA_WIDTH] ^ alu_s[DATA_WIDTH];

  always_comb begin
    fn_valid = 1'b0;
    fn_shift = 1'b0;
    fn_rot   = 1'b0;
    fn_long  = 1'b0;
    case (op_func)
      FN_ADD, FN_SUB, FN_AND, FN_OR: fn_valid = 1'b1;
      FN_MUL, FN_DIV: begin
        fn_valid = 1'b1;
        fn_long  = 1'b1;
      end
      FN_SLL, FN_SLR: begin
        fn_valid = 1'b1;
        fn_shift = 1'b1;
      end
      FN_ROL, FN_ROR: begin
        fn_valid = 1'b1;
        fn_shift = 1'b1;
        fn_rot   = 1'b1;
      end
      default: ;
    endcase
    // Shift distances are reduced modulo the word width before reaching the ALU.
    b_eff    = fn_shift ? {{(DATA_WIDTH-SH_W){1'b0}}, op_b[SH_W-1:0]} : op_b;
    div_zero = (op_func == FN_DIV) && (op_b == '0);
    rot_zero = fn_rot && (op_b[SH_W-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_ready  <= 1'b1;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      exc_valid <= 1'b0;
      exc_code  <= 2'd0;
      rd_q      <= '0;
      s_q       <= '0;
      long_q    <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            rd_q     <= op_rd;
            long_q   <= fn_long;
            op_ready <= 1'b0;
            if (!fn_valid || div_zero) begin
              // Rejected before the ALU sees it: operand registers keep their old values.
              state     <= EXC;
              exc_valid <= 1'b1;
              exc_code  <= fn_valid ? 2'd3 : 2'd2;
            end else if (rot_zero) begin
              state   <= WB_R;
              wb_en   <= 1'b1;
              wb_addr <= op_rd;
              wb_data <= op_a;
            end else begin
              state    <= EXEC;
              alu_a    <= op_a;
              alu_b    <= b_eff;
              alu_ctrl <= op_func;
            end
          end
        end
        EXEC: begin
          if (alu_exc) begin
            state     <= EXC;
            exc_valid <= 1'b1;
            exc_code  <= 2'd1;
          end else begin
            state   <= WB_R;
            wb_en   <= 1'b1;
            wb_addr <= rd_q;
            wb_data <= alu_r[DATA_WIDTH-1:0];
            s_q     <= alu_s[DATA_WIDTH-1:0];
          end
        end
        WB_R: begin
          if (long_q) begin
            // Second write lands after the R write, so S wins when rd == S_REG_ADDR.
            state   <= WB_S;
            wb_en   <= 1'b1;
            wb_addr <= S_REG_ADDR;
            wb_data <= s_q;
          end else begin
            state    <= IDLE;
            op_ready <= 1'b1;
          end
        end
        WB_S: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        EXC: begin
          if (exc_ack) begin
            state     <= IDLE;
            op_ready  <= 1'b1;
            exc_valid <= 1'b0;
            exc_code  <= 2'd0;
          end
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic ops_done, exc_enter;
  assign ops_done  = ((state == WB_R) && !long_q) || (state == WB_S);
  assign exc_enter = ((state == IDLE) && op_valid && op_ready && (!fn_valid || div_zero)) ||
                     ((state == EXEC) && alu_exc);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops <= 16'd0;
      stat_exc <= 16'd0;
    end else begin
      if (ops_done && (stat_ops != 16'hFFFF)) stat_ops <= stat_ops + 16'd1;
      if (exc_enter && (stat_exc != 16'hFFFF)) stat_exc <= stat_exc + 16'd1;
    end
  end
`else
  assign stat_ops = 16'd0;
  assign stat_exc = 16'd0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Purpose: randomized bench for alu_issue_ctrl against a per-operation schedule model.
// Latency: each accepted op expands into the exact list of cycles it must occupy.
// Backpressure: ops offered while busy must be ignored; exc_ack outside EXC must be ignored.
module tb_alu_issue_ctrl;

  localparam logic [3:0] ADD = 4'b1111, SUB = 4'b1110, AND_ = 4'b1101, OR_ = 4'b1100;
  localparam logic [3:0] MUL = 4'b0001, DIV = 4'b0010, SLL = 4'b1010, SLR = 4'b1011;
  localparam logic [3:0] ROL = 4'b1001, ROR = 4'b1000;

`ifdef ALU_ISSUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready;
  logic [3:0]  op_func;
  logic [15:0] op_a, op_b;
  logic [3:0]  op_rd;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [16:0] alu_r, alu_s;
  logic        alu_exc;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic        exc_ack;
  logic [15:0] stat_ops, stat_exc;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_func(op_func),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_r(alu_r), .alu_s(alu_s), .alu_exc(alu_exc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_ack(exc_ack),
    .stat_ops(stat_ops), .stat_exc(stat_exc)
  );

  // One record per cycle: what the outputs must be, and what the bench drives on the ALU/ack inputs.
  typedef struct {
    logic        rdy, wen, ev;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  ec;
    logic        alu_set;
    logic [15:0] aa, ab;
    logic [3:0]  ac;
    logic [16:0] dr, ds;
    logic        de, dack;
    logic        exc_entry, ops_done;
  } rec_t;

  rec_t q[$];
  logic [15:0] m_aa, m_ab, m_wdata, m_ops, m_exc;
  logic [3:0]  m_ac, m_waddr;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  function automatic rec_t idle_rec();
    rec_t x = '{default: 0};
    x.rdy = 1'b1;
    return x;
  endfunction

  function automatic rec_t busy_rec();
    rec_t x = '{default: 0};
    x.dr   = 17'($urandom);
    x.ds   = 17'($urandom);
    x.de   = 1'($urandom);
    x.dack = 1'($urandom);
    return x;
  endfunction

  function automatic void push_exc(input logic [1:0] code, input int ackd);
    rec_t x;
    for (int i = 0; i <= ackd; i++) begin
      x = busy_rec();
      x.ev = 1'b1;
      x.ec = code;
      x.dack = (i == ackd);
      x.exc_entry = (i == 0);
      q.push_back(x);
    end
  endfunction

  function automatic void push_wb(input logic [3:0] addr, input logic [15:0] data, input logic last);
    rec_t x = busy_rec();
    x.wen = 1'b1;
    x.waddr = addr;
    x.wdata = data;
    x.ops_done = last;
    q.push_back(x);
  endfunction

  // Expand one accepted operation into its cycle-by-cycle behaviour.
  function automatic void build(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] rd, input logic [16:0] r, input logic [16:0] s,
                                input logic e, input int ackd);
    rec_t x;
    bit valid, shift, is_long;
    valid   = f inside {ADD, SUB, AND_, OR_, MUL, DIV, SLL, SLR, ROL, ROR};
    shift   = f inside {SLL, SLR, ROL, ROR};
    is_long = f inside {MUL, DIV};
    if (!valid) push_exc(2'd2, ackd);
    else if (f == DIV && b == 16'd0) push_exc(2'd3, ackd);
    else if ((f == ROL || f == ROR) && (b % 16) == 0) push_wb(rd, a, 1'b1);
    else begin
      x = busy_rec();
      x.alu_set = 1'b1;
      x.aa = a;
      x.ab = shift ? (b % 16) : b;
      x.ac = f;
      x.dr = r;
      x.ds = s;
      x.de = e;
      q.push_back(x);
      if (e) push_exc(2'd1, ackd);
      else begin
        push_wb(rd, r[15:0], !is_long);
        if (is_long) push_wb(4'd15, s[15:0], 1'b1);
      end
    end
  endfunction

  task automatic compare(input rec_t E);
    check("op_ready",  32'(op_ready),  32'(E.rdy));
    check("wb_en",     32'(wb_en),     32'(E.wen));
    check("wb_addr",   32'(wb_addr),   32'(m_waddr));
    check("wb_data",   32'(wb_data),   32'(m_wdata));
    check("exc_valid", 32'(exc_valid), 32'(E.ev));
    check("exc_code",  32'(exc_code),  32'(E.ec));
    check("alu_a",     32'(alu_a),     32'(m_aa));
    check("alu_b",     32'(alu_b),     32'(m_ab));
    check("alu_ctrl",  32'(alu_ctrl),  32'(m_ac));
    check("stat_ops",  32'(stat_ops),  32'(m_ops));
    check("stat_exc",  32'(stat_exc),  32'(m_exc));
  endtask

  task automatic clear_model();
    q.delete();
    m_aa = '0; m_ab = '0; m_ac = '0; m_waddr = '0; m_wdata = '0; m_ops = '0; m_exc = '0;
  endtask

  // One clock cycle: check this cycle's outputs at the falling edge, then drive the next inputs.
  task automatic step(input logic v, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] rd, input logic [16:0] r, input logic [16:0] s,
                      input logic e, input int ackd, input logic do_rst);
    rec_t E;
    @(negedge clk);
    E = (q.size() > 0) ? q.pop_front() : idle_rec();
    if (E.alu_set) begin m_aa = E.aa; m_ab = E.ab; m_ac = E.ac; end
    if (E.wen) begin m_waddr = E.waddr; m_wdata = E.wdata; end
    if (STATS && E.exc_entry && m_exc != 16'hFFFF) m_exc = m_exc + 16'd1;
    compare(E);
    if (STATS && E.ops_done && m_ops != 16'hFFFF) m_ops = m_ops + 16'd1;
    rst = do_rst;
    op_valid = v && !do_rst;
    op_func = f; op_a = a; op_b = b; op_rd = rd;
    if (do_rst) begin
      clear_model();
      alu_r = 17'($urandom); alu_s = 17'($urandom); alu_exc = 1'($urandom); exc_ack = 1'($urandom);
    end else if (E.rdy) begin
      alu_r = 17'($urandom); alu_s = 17'($urandom); alu_exc = 1'($urandom); exc_ack = 1'($urandom);
      if (v) build(f, a, b, rd, r, s, e, ackd);
    end else begin
      alu_r = E.dr; alu_s = E.ds; alu_exc = E.de; exc_ack = E.dack;
    end
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 16'd0, 16'd0, 4'd0, 17'd0, 17'd0, 1'b0, 0, 1'b0);
  endtask

  task automatic rand_step();
    logic [3:0] fl[10] = '{ADD, SUB, AND_, OR_, MUL, DIV, SLL, SLR, ROL, ROR};
    logic [3:0] f;
    logic [15:0] b;
    f = ($urandom_range(0, 9) == 0) ? 4'($urandom) : fl[$urandom_range(0, 9)];
    b = 16'($urandom);
    if ($urandom_range(0, 3) == 0) b = (f inside {ROL, ROR}) ? (b & 16'hFFF0) : 16'd0;
    step(1'($urandom_range(0, 1)), f, 16'($urandom), b, 4'($urandom), 17'($urandom), 17'($urandom),
         $urandom_range(0, 4) == 0, $urandom_range(0, 4), 1'b0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_func = '0; op_a = '0; op_b = '0; op_rd = '0;
    alu_r = '0; alu_s = '0; alu_exc = 1'b0; exc_ack = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check("rst op_ready",  32'(op_ready), 32'd1);
    check("rst wb_en",     32'(wb_en), 32'd0);
    check("rst wb_data",   32'(wb_data), 32'd0);
    check("rst alu_ctrl",  32'(alu_ctrl), 32'd0);
    check("rst exc_valid", 32'(exc_valid), 32'd0);
    rst = 1'b0;

    // ADD 3+4 -> r2 = 7 two cycles after transfer.
    step(1'b1, ADD, 16'h0003, 16'h0004, 4'd2, 17'h00007, 17'h0, 1'b0, 0, 1'b0);
    idle();
    check("add cyc1 op_ready", 32'(op_ready), 32'd0);
    check("add cyc1 alu_b", 32'(alu_b), 32'h0004);
    idle();
    check("add cyc2 wb_en", 32'(wb_en), 32'd1);
    check("add cyc2 wb_addr", 32'(wb_addr), 32'd2);
    check("add cyc2 wb_data", 32'(wb_data), 32'h0007);
    idle();
    check("add cyc3 op_ready", 32'(op_ready), 32'd1);

    // MUL: R to r3, then S to r15.
    step(1'b1, MUL, 16'h0100, 16'h0100, 4'd3, 17'h00000, 17'h00001, 1'b0, 0, 1'b0);
    idle(); idle();
    check("mul R addr", 32'(wb_addr), 32'd3);
    check("mul R data", 32'(wb_data), 32'h0000);
    idle();
    check("mul S addr", 32'(wb_addr), 32'd15);
    check("mul S data", 32'(wb_data), 32'h0001);

    // DIV by zero: rejected without touching the ALU registers.
    idle();
    step(1'b1, DIV, 16'h1234, 16'h0000, 4'd5, 17'h0, 17'h0, 1'b0, 5, 1'b0);
    idle();
    check("div0 exc_code", 32'(exc_code), 32'd3);
    check("div0 alu_ctrl unchanged", 32'(alu_ctrl), 32'(MUL));
    for (int i = 0; i < 6; i++) idle();
    check("div0 op_ready after ack", 32'(op_ready), 32'd1);

    // ADD with ALU exception: code 1, no write.
    step(1'b1, ADD, 16'h7FFF, 16'h0001, 4'd4, 17'h08000, 17'h0, 1'b1, 2, 1'b0);
    idle(); idle();
    check("ovf exc_code", 32'(exc_code), 32'd1);
    check("ovf wb_en", 32'(wb_en), 32'd0);
    for (int i = 0; i < 3; i++) idle();

    // ROL by 16 bypasses the ALU; SLL by 0x13 presents distance 3.
    step(1'b1, ROL, 16'hABCD, 16'h0010, 4'd6, 17'h0, 17'h0, 1'b0, 0, 1'b0);
    idle();
    check("rol0 wb_en", 32'(wb_en), 32'd1);
    check("rol0 wb_data", 32'(wb_data), 32'hABCD);
    idle();
    step(1'b1, SLL, 16'h0001, 16'h0013, 4'd7, 17'h00008, 17'h0, 1'b0, 0, 1'b0);
    idle();
    check("sll alu_b", 32'(alu_b), 32'h0003);
    idle(); idle();

    for (int i = 0; i < 600; i++) rand_step();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle();
    idle();

    // Reset during the R write of a MUL abandons the S write.
    step(1'b1, MUL, 16'h00FF, 16'h0102, 4'd9, 17'h000FE, 17'h00001, 1'b0, 0, 1'b0);
    idle();
    step(1'b0, 4'd0, 16'd0, 16'd0, 4'd0, 17'd0, 17'd0, 1'b0, 0, 1'b1);
    check("rstmid in WB_R wb_addr", 32'(wb_addr), 32'd9);
    idle();
    check("rstmid wb_en", 32'(wb_en), 32'd0);
    check("rstmid wb_addr", 32'(wb_addr), 32'd0);
    check("rstmid alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rstmid stat_ops", 32'(stat_ops), 32'd0);
    idle(); idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
